// File: rtl/uart_rx_byte.sv
`default_nettype none
// ============================================================================
// Module  : uart_rx_byte
// Brief   : Oversampling UART receiver (8N1, or 8E1 when UART_RX_PARITY_EN is
//           defined); one-cycle data_valid / frame_err / parity_err strobes.
// Revision: 1.0 - initial release
// ============================================================================
module uart_rx_byte #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       frame_err,
  output logic       parity_err,
  output logic       busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'((CLKS_PER_BIT - 1) / 2);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_HIGH = 3'd5
  } state_t;

  state_t           state, state_next;
  logic             rx_meta, rx_s;
  logic [CNT_W-1:0] clk_cnt, clk_cnt_next;
  logic [2:0]       bit_idx, bit_idx_next;
  logic [7:0]       shift, shift_next, data_out_next;
  logic             data_valid_next, frame_err_next, parity_err_next;
  logic             parity_ok;

`ifdef UART_RX_PARITY_EN
  logic par_bit, par_bit_next;
  assign parity_ok = (par_bit == ^shift);  // even parity over the data byte
`else
  assign parity_ok = 1'b1;
`endif

  assign busy = (state != IDLE);

  // Sync flops reset to the idle-high line level so reset never fakes a start bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      clk_cnt    <= '0;
      bit_idx    <= '0;
      shift      <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit    <= 1'b0;
`endif
    end else begin
      state      <= state_next;
      clk_cnt    <= clk_cnt_next;
      bit_idx    <= bit_idx_next;
      shift      <= shift_next;
      data_out   <= data_out_next;
      data_valid <= data_valid_next;
      frame_err  <= frame_err_next;
      parity_err <= parity_err_next;
`ifdef UART_RX_PARITY_EN
      par_bit    <= par_bit_next;
`endif
    end
  end

  always_comb begin
    state_next      = state;
    clk_cnt_next    = clk_cnt + 1'b1;
    bit_idx_next    = bit_idx;
    shift_next      = shift;
    data_out_next   = data_out;
    data_valid_next = 1'b0;
    frame_err_next  = 1'b0;
    parity_err_next = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bit_next    = par_bit;
`endif
    case (state)
      IDLE: begin
        clk_cnt_next = '0;
        if (!rx_s) state_next = START;
      end
      START: begin
        if (clk_cnt == CNT_MID) begin
          clk_cnt_next = '0;
          bit_idx_next = '0;
          state_next   = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (clk_cnt == CNT_LAST) begin
          clk_cnt_next        = '0;
          shift_next[bit_idx] = rx_s;
          bit_idx_next        = bit_idx + 1'b1;
          if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_next = PARITY;
`else
            state_next = STOP;
`endif
          end
        end
      end
      PARITY: begin
`ifdef UART_RX_PARITY_EN
        if (clk_cnt == CNT_LAST) begin
          clk_cnt_next = '0;
          par_bit_next = rx_s;
          state_next   = STOP;
        end
`else
        state_next = IDLE;
`endif
      end
      STOP: begin
        // Leaving at mid stop bit gives half a bit to catch a back-to-back start.
        if (clk_cnt == CNT_LAST) begin
          clk_cnt_next = '0;
          if (!rx_s) begin
            frame_err_next = 1'b1;
            state_next     = WAIT_HIGH;
          end else if (parity_ok) begin
            data_out_next   = shift;
            data_valid_next = 1'b1;
            state_next      = IDLE;
          end else begin
            parity_err_next = 1'b1;
            state_next      = IDLE;
          end
        end
      end
      WAIT_HIGH: begin
        clk_cnt_next = '0;
        if (rx_s) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_byte.sv
`default_nettype none
// ============================================================================
// Module  : tb_uart_rx_byte
// Brief   : Self-checking bench for uart_rx_byte; frame-level reference model
//           predicts each strobe, its cycle and data_out. Honours UART_RX_PARITY_EN.
// Revision: 1.0 - initial release
// ============================================================================
module tb_uart_rx_byte;

  localparam int C = 16;
  localparam int H = (C - 1) / 2;
`ifdef UART_RX_PARITY_EN
  localparam int PBITS = 1;
`else
  localparam int PBITS = 0;
`endif
  localparam int EV_DV = 0;
  localparam int EV_FE = 1;
  localparam int EV_PE = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic [7:0] data_out;
  logic       data_valid, frame_err, parity_err, busy;

  int vectors    = 0;
  int miscompares = 0;
  int cyc        = 0;
  int last_good  = 0;

  typedef struct {
    int cyc;
    int kind;
    int data;
  } ev_t;

  ev_t exp_q[$];
  ev_t obs_q[$];
  ev_t mon_ev;

  uart_rx_byte #(.CLKS_PER_BIT(C)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .data_out   (data_out),
    .data_valid (data_valid),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int obs, input int exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Record every strobe with its cycle and the data_out seen alongside it.
  always @(negedge clk) begin
    if (!rst && (data_valid || frame_err || parity_err)) begin
      check("pulse_exclusive", int'(data_valid) + int'(frame_err) + int'(parity_err), 1);
      mon_ev.cyc  = cyc;
      mon_ev.kind = data_valid ? EV_DV : (frame_err ? EV_FE : EV_PE);
      mon_ev.data = int'(data_out);
      obs_q.push_back(mon_ev);
    end
  end

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    repeat (C) @(posedge clk);
    #1;
  endtask

  // Strobe lands mid stop bit: 2 sync + 1 + H + (9+PBITS)*C after rx is first sampled.
  task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic par_bad);
    ev_t e;
    int  k;
    k = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    if (PBITS == 1) drive_bit((^d) ^ par_bad);
    e.cyc = k + 1 + 3 + H + (9 + PBITS) * C;
    if (!stop_bit) begin
      e.kind = EV_FE;
      e.data = last_good;
    end else if (par_bad && PBITS == 1) begin
      e.kind = EV_PE;
      e.data = last_good;
    end else begin
      e.kind    = EV_DV;
      e.data    = int'(d);
      last_good = int'(d);
    end
    exp_q.push_back(e);
    drive_bit(stop_bit);
  endtask

  task automatic compare_events(input string tag);
    check({tag, " event_count"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      check($sformatf("%s ev%0d cycle", tag, i), obs_q[i].cyc, exp_q[i].cyc);
      check($sformatf("%s ev%0d kind", tag, i), obs_q[i].kind, exp_q[i].kind);
      check($sformatf("%s ev%0d data_out", tag, i), obs_q[i].data, exp_q[i].data);
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int   busy_cnt;
    int   hold;
    logic err, pb;
    logic [7:0] d;

    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset data_out", int'(data_out), 0);
    check("reset data_valid", int'(data_valid), 0);
    check("reset frame_err", int'(frame_err), 0);
    check("reset parity_err", int'(parity_err), 0);
    check("reset busy", int'(busy), 0);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    idle(2 * C);

    // Single good frame
    send_frame(8'hA5, 1'b1, 1'b0);
    idle(2 * C);
    compare_events("a5");
    check("a5 data_out", int'(data_out), 'hA5);

    // Back-to-back frames, no idle gap
    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    idle(2 * C);
    compare_events("b2b");
    check("b2b data_out", int'(data_out), 'hFF);

    // Short low glitch: false start, no strobes
    rx = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rx = 1'b1;
    busy_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
    end
    @(posedge clk);
    #1;
    check("glitch busy_in_range", int'(busy_cnt > 0 && busy_cnt <= 12), 1);
    check("glitch busy_end", int'(busy), 0);
    compare_events("glitch");

    // Framing error with line held low, then recovery
    send_frame(8'h11, 1'b1, 1'b0);
    send_frame(8'h3C, 1'b0, 1'b0);
    repeat (40) @(posedge clk);
    #1;
    @(negedge clk);
    check("break busy", int'(busy), 1);
    @(posedge clk);
    #1;
    idle(2 * C);
    check("break busy_after_high", int'(busy), 0);
    check("break data_out", int'(data_out), 'h11);
    send_frame(8'h5A, 1'b1, 1'b0);
    idle(2 * C);
    compare_events("break");
    check("break next data_out", int'(data_out), 'h5A);

    // Randomized frames: random bytes, gaps (incl. none), framing/parity faults
    for (int n = 0; n < 24; n++) begin
      d   = 8'($urandom);
      err = ($urandom_range(0, 5) == 0);
      pb  = (PBITS == 1) ? ($urandom_range(0, 4) == 0) : 1'b0;
      send_frame(d, ~err, pb);
      if (err) begin
        hold = $urandom_range(0, 40);
        repeat (hold) @(posedge clk);
        #1;
        idle(2 * C);
      end else begin
        idle($urandom_range(0, 2) * C);
      end
    end
    idle(2 * C);
    compare_events("random");
    check("random data_out", int'(data_out), last_good);
    check("random busy", int'(busy), 0);

    // Asynchronous reset during data bit 3 of 0xFF
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(1'b1);
    rx = 1'b1;
    repeat (C / 2) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midrst data_out", int'(data_out), 0);
    check("midrst data_valid", int'(data_valid), 0);
    check("midrst frame_err", int'(frame_err), 0);
    check("midrst parity_err", int'(parity_err), 0);
    check("midrst busy", int'(busy), 0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk);
    #1;
    last_good = 0;
    idle(2 * C);
    compare_events("midrst abort");
    send_frame(8'h81, 1'b1, 1'b0);
    idle(2 * C);
    compare_events("midrst");
    check("midrst next data_out", int'(data_out), 'h81);

`ifdef UART_RX_PARITY_EN
    // 0x07 carries even parity bit 1; flipping it must give parity_err only
    send_frame(8'h07, 1'b1, 1'b0);
    idle(2 * C);
    send_frame(8'h07, 1'b1, 1'b1);
    idle(2 * C);
    compare_events("parity");
    check("parity data_out", int'(data_out), 'h07);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
